load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles o_mem_req waits for i_mem_ack before a bus error.
REQ-002 i_clk  input  1  sole clock, rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  request from execute stage.
REQ-005 i_is_load / i_is_store  input  1 each  operation select.
REQ-006 i_funct3  input  3  width/sign select (lsu_decode::MemFunct).
REQ-007 i_addr  input  32  effective address, taken from ALU o_alu_res (ADD result).
REQ-008 i_store_data  input  32  rs2 value.
REQ-009 o_ready  output  1  high only in IDLE.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_load_data  output  32  extended load result, valid with o_done.
REQ-012 o_misaligned / o_bus_err  output  1 each  fault flags, valid with o_done.
REQ-013 o_mem_req, o_mem_we  output  1 each; o_mem_addr  output  32; o_mem_wdata  output  32; o_mem_be  output  4: memory request bus.
REQ-014 i_mem_ack  input  1; i_mem_rdata  input  32: memory response.

Function
REQ-015 States IDLE, BUSY, RESP; IDLE->BUSY on i_valid & o_ready & exactly one of i_is_load/i_is_store & aligned; BUSY->RESP on i_mem_ack or timeout; RESP->IDLE unconditionally.
REQ-016 Accepted request latched in accept cycle N; o_mem_req high from N+1, all request outputs stable until ack.
REQ-017 o_mem_addr = {i_addr[31:2],2'b00}; o_mem_be: byte = 1<<addr[1:0], half = 2'b11<<addr[1:0], word = 4'hF.
REQ-018 o_mem_wdata: byte replicated x4, half replicated x2, word unchanged; o_mem_we = store.
REQ-019 i_mem_ack in cycle M (M>=N+1, same cycle as first req allowed) -> o_done in M+1; load data captured at M.
REQ-020 Load extract by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; stores drive o_load_data = 0.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no memory request; IDLE->RESP directly, o_done and o_misaligned at N+1.
REQ-022 Both or neither of i_is_load/i_is_store with i_valid: treated as misaligned fault (o_misaligned), no memory request.
REQ-023 Timeout counter clears on accept, increments each BUSY cycle without ack; reaching TIMEOUT_CYCLES -> RESP, o_bus_err=1, o_mem_req drops.
REQ-024 i_valid while not IDLE ignored; i_mem_ack outside BUSY ignored.
REQ-025 Illegal i_funct3 (011, 110, 111, or store funct3 > 010) treated as misaligned fault.

Reset
REQ-026 i_rst_n low asynchronously forces IDLE; o_mem_req, o_mem_we, o_done, o_misaligned, o_bus_err, o_mem_be = 0; o_load_data, o_mem_addr, o_mem_wdata = 0; o_ready = 1 after release.
REQ-027 Reset mid-BUSY abandons the transaction; no o_done is produced for it.

Structure
REQ-028 Package lsu_decode holds MemFunct enum (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010) and LsuState enum; shared header include.
REQ-029 One combinational sub-module load_extend (funct3, addr[1:0], rdata -> 32-bit result).

Verification
REQ-030 SW addr 0x100, data 0xDEADBEEF, ack 2 cycles after req -> be=F, wdata=0xDEADBEEF, o_done one cycle after ack, no faults.
REQ-031 LB addr 0x103, rdata 0x80FF_0000 -> o_load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 LH addr 0x102, rdata 0x8001_1234 -> 0xFFFF8001; SH addr 0x102 data 0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD.
REQ-033 LW addr 0x101 -> no o_mem_req, o_done+o_misaligned at N+1; o_ready back next cycle.
REQ-034 TIMEOUT_CYCLES=4, no ack -> o_bus_err+o_done after 4 BUSY cycles, o_mem_req low thereafter.
REQ-035 Assert i_rst_n=0 while BUSY -> o_mem_req low immediately, no o_done; subsequent LW 0x0 completes normally.

Source files
------------

// File: rtl/lsu_decode.sv
// Shared decode definitions for the load/store unit: access widths, FSM states
// and the alignment / byte-enable / write-data helpers.
package lsu_decode;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } MemFunct;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } LsuState;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store) return (f3 <= SW);
        return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // f3[1:0] encodes the access size for both loads and stores.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return !lo[0];
            2'b10:   return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f3_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f3_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module load_extend
    import lsu_decode::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_o = {24'h0, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LHU:     result_o = {16'h0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> BUSY (memory request) -> RESP,
// with fault requests short-circuiting IDLE -> RESP and a bus timeout in BUSY.
module load_store_unit
    import lsu_decode::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    LsuState      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
    logic [3:0]   be_q, be_d;
    logic [2:0]   f3_q, f3_d;
    logic [1:0]   lo_q, lo_d;
    logic         we_q, we_d, mis_q, mis_d, berr_q, berr_d;
    logic         fault;
    logic [31:0]  ext;

    load_extend u_ext (
        .funct3_i  (f3_q),
        .addr_lo_i (lo_q),
        .rdata_i   (i_mem_rdata),
        .result_o  (ext)
    );

    // Ambiguous op select and illegal encodings share the misaligned fault path.
    assign fault = (i_is_load == i_is_store) || !f3_legal(i_funct3, i_is_store)
                || !f3_aligned(i_funct3, i_addr[1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        we_d    = we_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        case (state_q)
            IDLE: if (i_valid) begin
                mis_d   = fault;
                berr_d  = 1'b0;
                ldata_d = '0;
                cnt_d   = '0;
                if (fault) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                    addr_d  = {i_addr[31:2], 2'b00};
                    lo_d    = i_addr[1:0];
                    f3_d    = i_funct3;
                    we_d    = i_is_store;
                    be_d    = f3_be(i_funct3, i_addr[1:0]);
                    wdata_d = f3_wdata(i_funct3, i_store_data);
                end
            end
            BUSY: if (i_mem_ack) begin
                state_d = RESP;
                ldata_d = we_q ? 32'h0 : ext;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = RESP;
                berr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_done       = (state_q == RESP);
    assign o_mem_req    = (state_q == BUSY);
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_be     = be_q;
    assign o_load_data  = ldata_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        valid, is_load, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, sdata, mem_rdata;
    logic        ready, done, mis, berr, mem_req, mem_we;
    logic [31:0] ldata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          n_cmp = 0;
    int          n_bad = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_is_load(is_load),
        .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(sdata),
        .o_ready(ready), .o_done(done), .o_load_data(ldata), .o_misaligned(mis),
        .o_bus_err(berr), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accept cycle; returns in cycle N+1.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; sdata = d;
        step();
        valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic ack_after(input string tag, input int waits, input logic [31:0] rd);
        for (int i = 0; i < waits; i++) begin
            chk({tag, " req_wait"}, 32'(mem_req), 32'd1);
            chk({tag, " done_wait"}, 32'(done), 32'd0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = rd;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic resp_check(input string tag, input logic [31:0] data,
                              input logic m, input logic b);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " ldata"}, ldata, data);
        chk({tag, " mis"}, 32'(mis), 32'(m));
        chk({tag, " berr"}, 32'(berr), 32'(b));
        chk({tag, " req_resp"}, 32'(mem_req), 32'd0);
        step();
        chk({tag, " done_clr"}, 32'(done), 32'd0);
        chk({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = 32'h0; sdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst flags", {30'd0, mis, berr}, 32'd0);
        chk("rst be_we", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst ldata", ldata, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst ready", 32'(ready), 32'd1);

        // SW 0x100 with a second request held on i_valid while busy (must be ignored)
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw req", 32'(mem_req), 32'd1);
        chk("sw we", 32'(mem_we), 32'd1);
        chk("sw addr", mem_addr, 32'h100);
        chk("sw be", 32'(mem_be), 32'hF);
        chk("sw wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw ready", 32'(ready), 32'd0);
        valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h300;
        step();
        chk("sw addr_hold", mem_addr, 32'h100);
        valid = 1'b0; is_load = 1'b0;
        ack_after("sw", 1, 32'h0);
        resp_check("sw", 32'h0, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb be", 32'(mem_be), 32'h8);
        chk("lb we", 32'(mem_we), 32'd0);
        chk("lb addr", mem_addr, 32'h100);
        ack_after("lb", 0, 32'h80FF0000);
        resp_check("lb", 32'hFFFFFF80, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        ack_after("lbu", 1, 32'h80FF0000);
        resp_check("lbu", 32'h00000080, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh be", 32'(mem_be), 32'hC);
        ack_after("lh", 0, 32'h80011234);
        resp_check("lh", 32'hFFFF8001, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
        ack_after("lhu", 0, 32'h80011234);
        resp_check("lhu", 32'h00008001, 1'b0, 1'b0);

        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD);
        chk("sh be", 32'(mem_be), 32'hC);
        chk("sh wdata", mem_wdata, 32'hABCDABCD);
        ack_after("sh", 1, 32'hFFFFFFFF);
        resp_check("sh", 32'h0, 1'b0, 1'b0);

        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234565A);
        chk("sb be", 32'(mem_be), 32'h2);
        chk("sb wdata", mem_wdata, 32'h5A5A5A5A);
        ack_after("sb", 0, 32'h0);
        resp_check("sb", 32'h0, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        resp_check("lw_mis", 32'h0, 1'b1, 1'b0);

        issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        resp_check("ld_bad_f3", 32'h0, 1'b1, 1'b0);

        issue(1'b0, 1'b1, 3'b100, 32'h0, 32'h0);
        resp_check("st_bad_f3", 32'h0, 1'b1, 1'b0);

        issue(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
        resp_check("ld_and_st", 32'h0, 1'b1, 1'b0);

        // Timeout: four BUSY cycles without ack, then the bus error response
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to req", 32'(mem_req), 32'd1);
            chk("to done", 32'(done), 32'd0);
            step();
        end
        resp_check("timeout", 32'h0, 1'b0, 1'b1);
        chk("to req_after", 32'(mem_req), 32'd0);

        // Reset while BUSY
        issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        chk("rb req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rb req_drop", 32'(mem_req), 32'd0);
        chk("rb ready", 32'(ready), 32'd1);
        #3 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rb no_done", 32'(done), 32'd0);
            step();
        end
        issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        ack_after("rb lw", 0, 32'h12345678);
        resp_check("rb lw", 32'h12345678, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
